// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC APB read-back block: register word
// indices, field widths and the read FSM state encoding.
package ttc_pkg;

  // Field widths of the live register sources
  localparam int CTRL_W    = 7;
  localparam int CNT_W     = 16;
  localparam int INTR_W    = 6;

  // Word index width (paddr[4:2])
  localparam int WIDX_W    = 3;

  // Register map, expressed as word indices (byte offset >> 2)
  localparam logic [WIDX_W-1:0] WIDX_CLK_CTRL    = 3'd0; // 0x00
  localparam logic [WIDX_W-1:0] WIDX_CNTR_CTRL   = 3'd1; // 0x04
  localparam logic [WIDX_W-1:0] WIDX_COUNTER     = 3'd2; // 0x08
  localparam logic [WIDX_W-1:0] WIDX_INTERVAL    = 3'd3; // 0x0C
  localparam logic [WIDX_W-1:0] WIDX_INTR_STATUS = 3'd4; // 0x10
  localparam logic [WIDX_W-1:0] WIDX_INTR_EN     = 3'd5; // 0x14

  // Read FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ttc_rd_mux.sv
// Combinational address decode and read multiplexer. Narrow fields are
// zero-extended; unmapped word indices return zero and flag an error.
module ttc_rd_mux
  import ttc_pkg::*;
(
  input  logic [WIDX_W-1:0] i_widx,
  input  logic [CTRL_W-1:0] i_clk_ctrl,
  input  logic [CTRL_W-1:0] i_cntr_ctrl,
  input  logic [CNT_W-1:0]  i_counter,
  input  logic [CNT_W-1:0]  i_interval,
  input  logic [INTR_W-1:0] i_intr_status,
  input  logic [INTR_W-1:0] i_intr_en,
  output logic [31:0]       o_data,
  output logic              o_err
);

  // Select the addressed register value
  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_widx)
      WIDX_CLK_CTRL:    o_data = {{(32-CTRL_W){1'b0}}, i_clk_ctrl};
      WIDX_CNTR_CTRL:   o_data = {{(32-CTRL_W){1'b0}}, i_cntr_ctrl};
      WIDX_COUNTER:     o_data = {{(32-CNT_W){1'b0}}, i_counter};
      WIDX_INTERVAL:    o_data = {{(32-CNT_W){1'b0}}, i_interval};
      WIDX_INTR_STATUS: o_data = {{(32-INTR_W){1'b0}}, i_intr_status};
      WIDX_INTR_EN:     o_data = {{(32-INTR_W){1'b0}}, i_intr_en};
      default:          o_err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ttc_apb_rdback.sv
// APB read-back slave for the TTC. Reads snapshot the addressed value in
// the setup cycle, insert one wait state, then respond. Reading interrupt
// status emits a one-cycle clear pulse carrying exactly the bits returned,
// so status bits rising after the snapshot survive. Writes complete
// immediately with zero wait states and are otherwise ignored here.
module ttc_apb_rdback
  import ttc_pkg::*;
(
  input  logic              pclk,
  input  logic              p_reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [4:0]        paddr,
  input  logic [CTRL_W-1:0] clk_ctrl_reg_in,
  input  logic [CTRL_W-1:0] cntr_ctrl_reg_in,
  input  logic [CNT_W-1:0]  counter_val_in,
  input  logic [CNT_W-1:0]  interval_reg_in,
  input  logic [INTR_W-1:0] intr_status_in,
  input  logic [INTR_W-1:0] intr_en_in,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [INTR_W-1:0] intr_clr
);

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDX_W-1:0]   r_addr;
  logic [31:0]         r_snap;
  logic                r_err;
  logic [INTR_W-1:0]   r_intr_clr;

  logic [31:0]         w_mux_data;
  logic                w_mux_err;
  logic                w_setup_rd;
  logic                w_wr_acc;
  logic                w_resp;
  logic [1:0]          w_unused_paddr;

  // Byte-lane bits of the address carry no meaning for word registers
  assign w_unused_paddr = paddr[1:0];

  assign w_setup_rd = (r_state == IDLE) && psel && !penable && !pwrite;
  assign w_wr_acc   = (r_state == IDLE) && psel && penable && pwrite;
  // A response is only presented while the master still selects us
  assign w_resp     = (r_state == RESP) && psel;

  ttc_rd_mux u_rd_mux (
    .i_widx        (paddr[4:2]),
    .i_clk_ctrl    (clk_ctrl_reg_in),
    .i_cntr_ctrl   (cntr_ctrl_reg_in),
    .i_counter     (counter_val_in),
    .i_interval    (interval_reg_in),
    .i_intr_status (intr_status_in),
    .i_intr_en     (intr_en_in),
    .o_data        (w_mux_data),
    .o_err         (w_mux_err)
  );

  // Next-state logic: setup -> one wait state -> response -> idle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_setup_rd) w_state_next = CAPT;
      CAPT:    w_state_next = psel ? RESP : IDLE;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge pclk) begin
    if (p_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Address and data snapshot taken on the setup cycle of a read
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      r_addr <= '0;
      r_snap <= '0;
      r_err  <= 1'b0;
    end else if (w_setup_rd) begin
      r_addr <= paddr[4:2];
      r_snap <= w_mux_data;
      r_err  <= w_mux_err;
    end
  end

  // Clear pulse in the cycle after a completed error-free status read
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      r_intr_clr <= '0;
    end else if (w_resp && !r_err && (r_addr == WIDX_INTR_STATUS)) begin
      r_intr_clr <= r_snap[INTR_W-1:0];
    end else begin
      r_intr_clr <= '0;
    end
  end

  // APB response outputs; zero except in a live response or write access
  always_comb begin
    prdata  = w_resp ? r_snap : 32'd0;
    pready  = w_resp || w_wr_acc;
    pslverr = w_resp && r_err;
  end

  assign intr_clr = r_intr_clr;

endmodule

// File: doc/ttc_apb_rdback.md
TTC_APB_RDBACK -- requirements
Module: ttc_apb_rdback

Interface
REQ-001 SHALL have port pclk, input, 1 bit: APB system clock; all logic on its rising edge.
REQ-002 SHALL have port p_reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports psel, penable, pwrite, all input, 1 bit: APB transfer controls.
REQ-004 SHALL have port paddr, input, 5 bits: byte address; bits [1:0] ignored.
REQ-005 SHALL have ports clk_ctrl_reg_in and cntr_ctrl_reg_in, input, 7 bits each: live control register values.
REQ-006 SHALL have ports counter_val_in and interval_reg_in, input, 16 bits each: live counter and interval values.
REQ-007 SHALL have ports intr_status_in and intr_en_in, input, 6 bits each: live interrupt status and enable values.
REQ-008 SHALL have port prdata, output, 32 bits: read data.
REQ-009 SHALL have ports pready and pslverr, output, 1 bit each: APB completion and error.
REQ-010 SHALL have port intr_clr, output, 6 bits: one-cycle clear-on-read pulse to the interrupt block.

Function
REQ-011 SHALL decode the register map: 0x00 clk_ctrl, 0x04 cntr_ctrl, 0x08 counter, 0x0C interval, 0x10 intr_status, 0x14 intr_en; narrower fields are zero-extended to 32 bits.
REQ-012 SHALL use FSM states IDLE, CAPT, RESP.
REQ-013 IDLE->CAPT SHALL occur when psel=1, penable=0 and pwrite=0 (read setup cycle).
REQ-014 On the IDLE->CAPT edge, the block SHALL latch the word address and snapshot the addressed value into a 32-bit holding register.
REQ-015 The CAPT state SHALL drive pready=0, giving exactly one wait state, and SHALL go to RESP.
REQ-016 The RESP state SHALL drive pready=1 and prdata equal to the snapshot, then return to IDLE.
REQ-017 Read latency SHALL be setup + 2 access cycles.
REQ-018 For an unmapped address (0x18-0x1C), RESP SHALL drive pslverr=1 and prdata=0; for mapped addresses pslverr SHALL be 0.
REQ-019 Writes SHALL complete with zero wait states: pready=1 and prdata=0 whenever psel=1, penable=1 and pwrite=1 in IDLE; the FSM SHALL not leave IDLE.
REQ-020 Outside RESP and outside write-access cycles, pready, pslverr and prdata SHALL be 0.
REQ-021 intr_clr SHALL pulse for exactly one cycle, in the cycle after RESP of an error-free 0x10 read, and SHALL equal the snapshotted status.
REQ-022 Status bits that rise after the snapshot SHALL NOT be cleared.
REQ-023 If psel drops in CAPT or RESP, the FSM SHALL return to IDLE next cycle with no intr_clr pulse and no pready.
REQ-024 A new setup cycle arriving in the cycle after RESP SHALL be accepted normally (back-to-back reads).

Reset
REQ-025 While p_reset=1 at a pclk edge, the FSM SHALL go to IDLE and the snapshot and address registers SHALL clear to 0.
REQ-026 prdata, pready, pslverr and intr_clr SHALL all be 0 after reset.
REQ-027 A reset asserted mid-transfer SHALL abort the transfer with no pready and no intr_clr pulse.

Structure
REQ-028 A shared package ttc_pkg SHALL hold the register offset constants, field widths (7, 16, 6) and the FSM state enum.
REQ-029 The address-decode/read-mux SHALL be one combinational sub-module, ttc_rd_mux, instantiated once; the FSM, snapshot and intr_clr logic SHALL live in the top module.

Verification
REQ-030 Reset then idle: prdata=0, pready=0, pslverr=0, intr_clr=0 for 10 cycles.
REQ-031 Read 0x08 with counter_val_in=0x1234 at setup, changing to 0x1235 during CAPT: pready=1 two cycles after setup, prdata=0x00001234.
REQ-032 intr_status_in=0x05 at setup of a 0x10 read, bit 1 rising during CAPT: prdata=0x05, then intr_clr=0x05 for one cycle.
REQ-033 Read 0x18: RESP has pslverr=1, prdata=0, no intr_clr.
REQ-034 Write 0x00: pready=1 in the first access cycle, prdata=0, FSM remains IDLE.
REQ-035 p_reset asserted during CAPT of a 0x10 read: no pready, intr_clr stays 0, and a following 0x04 read with cntr_ctrl_reg_in=0x7F returns 0x7F.
